// File: rtl/spi_master.sv
// SPI master: single clock, synchronous active-low reset (nreset).
// Frame of up to DATA_WIDTH bits, MSB first, all four SPI modes, SCK
// half-period of clk_div+1 clk cycles.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to add a loopback input
// that feeds the master's own mosi bit back into the receive path.
module spi_master #(
    parameter int DATA_WIDTH = 120,
    parameter int CNT_WIDTH  = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  bit_count,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sck,
    output logic                  mosi,
    output logic                  ncs
);

    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int HALF_W = DIV_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [HALF_W-1:0]     cnt_reg, cnt_next;
    logic [EDGE_W-1:0]     edge_reg, edge_next;
    logic [DIV_WIDTH-1:0]  div_reg, div_next;
    logic                  cpol_reg, cpol_next;
    logic                  cpha_reg, cpha_next;
    logic                  first_reg, first_next;
    logic [DATA_WIDTH-1:0] tx_reg, tx_next;
    logic [DATA_WIDTH-1:0] rx_reg, rx_next;
    logic                  sck_reg, sck_next;
    logic                  ncs_reg, ncs_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;

    logic [31:0]           n_req;
    logic [EDGE_W-1:0]     edges_req;
    logic                  mosi_int;
    logic                  sample_bit;
    logic                  leading;

    // Requested frame length, clamped to the shift register, as SCK edge count.
    assign n_req     = 32'(bit_count);
    assign edges_req = (n_req > 32'(DATA_WIDTH)) ? EDGE_W'(2 * DATA_WIDTH)
                                                 : EDGE_W'(n_req << 1);

    // mosi is forced low whenever the slave is not selected.
    assign mosi_int = tx_reg[DATA_WIDTH-1] & ~ncs_reg;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = loopback ? mosi_int : miso;
`else
    assign sample_bit = miso;
`endif

    // An edge that leaves the idle level of SCK is a leading edge.
    assign leading = (sck_reg == cpol_reg);

    // Next-state and datapath logic; every phase counts cnt_reg down to zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        edge_next  = edge_reg;
        div_next   = div_reg;
        cpol_next  = cpol_reg;
        cpha_next  = cpha_reg;
        first_next = first_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        sck_next   = sck_reg;
        ncs_next   = ncs_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // The done cycle itself never accepts a new request.
                if (start && !done_reg) begin
                    div_next   = clk_div;
                    cpol_next  = cpol;
                    cpha_next  = cpha;
                    tx_next    = tx_data;
                    rx_next    = '0;
                    sck_next   = cpol;
                    first_next = 1'b1;
                    busy_next  = 1'b1;
                    edge_next  = edges_req;
                    if (edges_req == '0) begin
                        // Empty frame: no chip select, straight to completion.
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else begin
                        // Setup phase runs clk_div+2 cycles, giving the
                        // (2N+2)*(clk_div+1)+1 cycle frame latency.
                        state_next = SETUP;
                        ncs_next   = 1'b0;
                        cnt_next   = {1'b0, clk_div} + 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = XFER;
                    cnt_next   = {1'b0, div_reg};
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            XFER: begin
                if (cnt_reg == '0) begin
                    cnt_next  = {1'b0, div_reg};
                    sck_next  = ~sck_reg;
                    edge_next = edge_reg - 1'b1;
                    if (leading ^ cpha_reg) begin
                        rx_next = {rx_reg[DATA_WIDTH-2:0], sample_bit};
                    end else if (cpha_reg && first_reg) begin
                        // First bit is already on mosi; the first shift edge keeps it.
                        first_next = 1'b0;
                    end else begin
                        tx_next = tx_reg << 1;
                    end
                    if (edge_reg == EDGE_W'(1)) begin
                        state_next = HOLD;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    ncs_next   = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers; reset aborts any frame without done.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_reg   <= '0;
            edge_reg  <= '0;
            div_reg   <= '0;
            cpol_reg  <= 1'b0;
            cpha_reg  <= 1'b0;
            first_reg <= 1'b0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            sck_reg   <= 1'b0;
            ncs_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            edge_reg  <= edge_next;
            div_reg   <= div_next;
            cpol_reg  <= cpol_next;
            cpha_reg  <= cpha_next;
            first_reg <= first_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            sck_reg   <= sck_next;
            ncs_reg   <= ncs_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign rx_data = rx_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign sck     = sck_reg;
    assign ncs     = ncs_reg;
    assign mosi    = mosi_int;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: directed and random frames against a behavioural
// SPI slave model that watches sck/ncs and drives miso.
module tb_spi_master;

    localparam int DW = 120;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    bit_count = '0;
    logic [7:0]    clk_div = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          done;
    logic          sck;
    logic          mosi;
    logic          ncs;

    int checks = 0;
    int failures = 0;

    spi_master dut (
        .clk       (clk),
        .nreset    (nreset),
        .start     (start),
        .bit_count (bit_count),
        .clk_div   (clk_div),
        .cpol      (cpol),
        .cpha      (cpha),
        .tx_data   (tx_data),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback  (loopback),
`endif
        .miso      (miso),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .sck       (sck),
        .mosi      (mosi),
        .ncs       (ncs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One complete frame: slave model drives miso on its shift edges and
    // captures mosi on its sample edges; expectations come from SPI rules.
    task automatic run_frame(input string tag, input int n, input int d, input bit cp,
                             input bit ch, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                             input bit noisy, input bit lb);
        int nexp;
        int k;
        int edges;
        int sidx;
        int done_at;
        int ncs_bad;
        bit lead;
        logic prev_sck;
        logic [DW-1:0] mosi_got;
        logic [DW-1:0] exp_mosi;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] mask;
        nexp = (n > DW) ? DW : n;
        k = (nexp == 0) ? 1 : (2 * nexp + 2) * (d + 1) + 1;
        edges = 0;
        done_at = -1;
        ncs_bad = 0;
        mosi_got = '0;
        sidx = ch ? -1 : 0;
        @(negedge clk);
        bit_count = 8'(n);
        clk_div = 8'(d);
        cpol = cp;
        cpha = ch;
        tx_data = tx;
        start = 1'b1;
        miso = (!ch && nexp > 0 && !lb) ? sw[nexp-1] : 1'b0;
        @(negedge clk);
        chk($sformatf("%s_busy_on", tag), DW'(busy), DW'(1));
        chk($sformatf("%s_ncs_on", tag), DW'(ncs), DW'(nexp == 0));
        chk($sformatf("%s_sck_idle", tag), DW'(sck), DW'(cp));
        // Changing inputs after acceptance must not affect the frame.
        start = 1'b0;
        tx_data = DW'({$urandom, $urandom, $urandom, $urandom});
        bit_count = 8'($urandom);
        clk_div = 8'($urandom);
        cpol = ~cp;
        cpha = ~ch;
        prev_sck = sck;
        for (int c = 1; c <= k + 20; c++) begin
            start = (noisy && c < k - 2) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (sck !== prev_sck) begin
                edges++;
                lead = (prev_sck == cp);
                if (lead ^ ch) begin
                    mosi_got = {mosi_got[DW-2:0], mosi};
                end else begin
                    sidx++;
                    miso = (!lb && sidx >= 0 && sidx < nexp) ? sw[nexp-1-sidx] : 1'b0;
                end
            end
            prev_sck = sck;
            if (done) begin
                done_at = c;
                break;
            end
            if (ncs !== (nexp == 0)) ncs_bad++;
        end
        start = 1'b0;
        exp_mosi = (nexp == 0) ? '0 : (tx >> (DW - nexp));
        mask = '1;
        if (nexp < DW) mask = (DW'(1) << nexp) - DW'(1);
        exp_rx = sw & mask;
        chk($sformatf("%s_done_cycle", tag), DW'(done_at), DW'(k));
        chk($sformatf("%s_sck_edges", tag), DW'(edges), DW'(2 * nexp));
        chk($sformatf("%s_mosi_bits", tag), mosi_got, exp_mosi);
        chk($sformatf("%s_rx_data", tag), rx_data, exp_rx);
        chk($sformatf("%s_ncs_frame", tag), DW'(ncs_bad), DW'(0));
        chk($sformatf("%s_ncs_end", tag), DW'(ncs), DW'(1));
        chk($sformatf("%s_busy_end", tag), DW'(busy), DW'(0));
        chk($sformatf("%s_mosi_end", tag), DW'(mosi), DW'(0));
        chk($sformatf("%s_sck_end", tag), DW'(sck), DW'(cp));
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), DW'(done), DW'(0));
        chk($sformatf("%s_rx_hold", tag), rx_data, exp_rx);
        $display("frame %s n=%0d div=%0d mode=%0d done_at=%0d rx=%0h", tag, n, d,
                 {cp, ch}, done_at, rx_data);
    endtask

    initial begin
        logic [DW-1:0] v;
        int e;
        logic p;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ncs", DW'(ncs), DW'(1));
        chk("rst_sck", DW'(sck), DW'(0));
        chk("rst_mosi", DW'(mosi), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_rx", rx_data, DW'(0));
        nreset = 1'b1;
        @(negedge clk);

        // Mode 0 reference frame
        v = '0;
        v[DW-1 -: 16] = 16'hA55A;
        run_frame("m0_a55a", 16, 0, 1'b0, 1'b0, v, DW'(16'h1234), 1'b0, 1'b0);

        // Modes 1..3 at clk_div=3
        v = '0;
        v[DW-1 -: 8] = 8'hC3;
        run_frame("m1_c3", 8, 3, 1'b0, 1'b1, v, DW'(8'h5A), 1'b0, 1'b0);
        run_frame("m2_c3", 8, 3, 1'b1, 1'b0, v, DW'(8'h5A), 1'b0, 1'b0);
        run_frame("m3_c3", 8, 3, 1'b1, 1'b1, v, DW'(8'h5A), 1'b0, 1'b0);

        // Full width and clamped length
        run_frame("full", 120, 1, 1'b0, 1'b0, '1, '1, 1'b0, 1'b0);
        run_frame("clamp", 200, 1, 1'b0, 1'b0, DW'({$urandom, $urandom, $urandom, $urandom}),
                  DW'({$urandom, $urandom, $urandom, $urandom}), 1'b0, 1'b0);

        // Empty frame
        run_frame("zero", 0, 2, 1'b1, 1'b0, '1, '1, 1'b0, 1'b0);

        // start held high across an empty frame: ignored in the done cycle,
        // re-accepted on the next idle cycle
        @(negedge clk);
        bit_count = 8'd0;
        start = 1'b1;
        @(negedge clk);
        chk("hold_busy0", DW'(busy), DW'(1));
        @(negedge clk);
        chk("hold_done1", DW'({done, busy}), DW'(2'b10));
        @(negedge clk);
        chk("hold_gap", DW'({done, busy}), DW'(2'b00));
        @(negedge clk);
        chk("hold_retrig", DW'(busy), DW'(1));
        start = 1'b0;
        @(negedge clk);
        chk("hold_done2", DW'(done), DW'(1));
        @(negedge clk);

        // Reset during bit 5 of a 32-bit frame
        bit_count = 8'd32;
        clk_div = 8'd1;
        cpol = 1'b0;
        cpha = 1'b1;
        tx_data = '1;
        miso = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        p = sck;
        for (int c = 0; c < 500 && e < 10; c++) begin
            @(negedge clk);
            if (sck !== p) e++;
            p = sck;
        end
        chk("abort_reach", DW'(e), DW'(10));
        nreset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("abort_state", DW'({ncs, sck, busy, done, mosi}), DW'(5'b10000));
        chk("abort_rx", rx_data, DW'(0));
        nreset = 1'b1;
        start = 1'b0;
        e = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) e++;
        end
        chk("abort_quiet", DW'(e), DW'(0));
        run_frame("after_abort", 32, 1, 1'b0, 1'b1, DW'({$urandom, $urandom, $urandom, $urandom}),
                  DW'({$urandom, $urandom, $urandom, $urandom}), 1'b0, 1'b0);

        // Random frames with stray start pulses while busy
        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("rnd%0d", i), int'($urandom_range(130, 1)),
                      int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom),
                      DW'({$urandom, $urandom, $urandom, $urandom}),
                      DW'({$urandom, $urandom, $urandom, $urandom}), 1'b1, 1'b0);
        end

`ifdef SPI_MASTER_LOOPBACK_EN
        // Loopback: receive the master's own transmit word, miso held low
        loopback = 1'b1;
        v = '0;
        v[DW-1 -: 32] = 32'hDEADBEEF;
        run_frame("loopback", 32, 1, 1'b0, 1'b0, v, DW'(32'hDEADBEEF), 1'b0, 1'b1);
        loopback = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
